// File: rtl/boot_rcv_loader.sv
// Boot loader: pulls bytes from the serial receive buffer, parses one load frame and
// writes little-endian 32-bit words to boot RAM. Optional inter-byte timeout: BOOT_TIMEOUT_EN.
module boot_rcv_loader #(
   parameter int unsigned        ADDR_W      = 16,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
   parameter logic [7:0]         SYNC_BYTE   = 8'hA5,
   parameter int unsigned        TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_ready_i,
   input  logic [7:0]        rx_data_i,
   output logic              rx_read_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
);

   typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StChk} state_e;

   state_e            state_q, state_d;
   logic              rx_read_q, rx_read_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [1:0]        lane_q, lane_d;
   logic [23:0]       word_q, word_d;
   logic [7:0]        acc_q, acc_d;
   logic              accept;
   logic              tmo_fire;

   // The buffer's ready lags our read pulse by a cycle, so never accept while reading.
   assign accept = rx_ready_i && !rx_read_q;

`ifdef BOOT_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TmoW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q + TmoW'(1);
      if (state_q == StIdle || accept) begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign tmo_fire = (state_q != StIdle) && !accept && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign tmo_fire   = 1'b0;
`endif

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         rx_read_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
         len_q      <= '0;
         word_cnt_q <= '0;
         lane_q     <= '0;
         word_q     <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         rx_read_q  <= rx_read_d;
         mem_we_q   <= mem_we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         acc_q      <= acc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (tmo_fire) begin
         state_d = StIdle;
      end else if (accept) begin
         unique case (state_q)
            StIdle:  if (rx_data_i == SYNC_BYTE) state_d = StLen0;
            StLen0:  state_d = StLen1;
            StLen1:  state_d = ({rx_data_i, len_q[7:0]} == 16'd0) ? StChk : StData;
            StData: begin
               if (lane_q == 2'd3 && word_cnt_q == len_q - 16'd1) state_d = StChk;
            end
            StChk:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Output and datapath next-values
   always_comb begin
      rx_read_d  = accept;
      mem_we_d   = 1'b0;
      addr_d     = mem_we_q ? addr_q + ADDR_W'(1) : addr_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      lane_d     = lane_q;
      word_d     = word_q;
      acc_d      = acc_q;
      if (tmo_fire) begin
         err_d      = 1'b1;
         err_code_d = 2'b10;
      end else if (accept) begin
         unique case (state_q)
            StLen0: len_d[7:0] = rx_data_i;
            StLen1: begin
               len_d[15:8] = rx_data_i;
               acc_d       = '0;
               addr_d      = BASE_ADDR;
               word_cnt_d  = '0;
               lane_d      = '0;
            end
            StData: begin
               acc_d  = acc_q + rx_data_i;
               lane_d = lane_q + 2'd1;
               // Lanes shift in from the top so byte 0 lands in bits 7:0 at lane 3.
               word_d = {rx_data_i, word_q[23:8]};
               if (lane_q == 2'd3) begin
                  mem_we_d   = 1'b1;
                  wdata_d    = {rx_data_i, word_q};
                  word_cnt_d = word_cnt_q + 16'd1;
               end
            end
            StChk: begin
               if (8'(acc_q + rx_data_i) == 8'h00) begin
                  done_d = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   assign rx_read_o   = rx_read_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_boot_rcv_loader.sv
// Self-checking bench for boot_rcv_loader: frame-level reference model driving
// per-byte expected effects, compared against the DUT every cycle.
module tb_boot_rcv_loader;

   localparam int unsigned      AW   = 2;
   localparam logic [AW-1:0]    BASE = 2'd3;
   localparam int unsigned      TMO  = 100;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_ready_i;
   logic [7:0]    rx_data_i;
   logic          rx_read_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [1:0]    err_code_o;

   always #5 clk = ~clk;

   boot_rcv_loader #(
      .ADDR_W      (AW),
      .BASE_ADDR   (BASE),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_ready_i  (rx_ready_i),
      .rx_data_i   (rx_data_i),
      .rx_read_o   (rx_read_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .err_code_o  (err_code_o)
   );

   // What accepting one byte must cause in the following cycle
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          done;
      logic          err;
      logic          busy;
   } eff_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic          e_read, e_we, e_done, e_err, e_busy;
   logic [AW-1:0] e_addr;
   logic [31:0]   e_data;
   logic [1:0]    e_code;
   int            since = 0;
   int            last_acc_cyc = 0;
   eff_t          cur;
   logic          cmp_en = 1'b0;

   int            n_we = 0, n_read = 0, n_consec = 0, n_done = 0, n_err = 0, err_cyc = 0;
   logic          prev_read = 1'b0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   last_data;
   logic [7:0]    pl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rx_read", 32'(rx_read_o), 32'(e_read));
         chk("mem_we", 32'(mem_we_o), 32'(e_we));
         chk("done", 32'(done_o), 32'(e_done));
         chk("err", 32'(err_o), 32'(e_err));
         chk("err_code", 32'(err_code_o), 32'(e_code));
         chk("busy", 32'(busy_o), 32'(e_busy));
         if (e_we) begin
            chk("mem_addr", 32'(mem_addr_o), 32'(e_addr));
            chk("mem_wdata", mem_wdata_o, e_data);
         end
         if (mem_we_o) begin
            n_we++;
            wr_addr.push_back(mem_addr_o);
            last_data = mem_wdata_o;
         end
         if (rx_read_o) begin
            n_read++;
            if (prev_read) n_consec++;
         end
         prev_read = rx_read_o;
         if (done_o) n_done++;
         if (err_o) begin
            n_err++;
            err_cyc = cyc;
         end
      end
   end

   // One clock: the model decides acceptance from the buffer's view of the handshake.
   task automatic step();
      logic acc;
      @(posedge clk);
      acc = rx_ready_i && !e_read;
      #1;
      cyc++;
      e_we   = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (reset) begin
         e_read = 1'b0;
         e_busy = 1'b0;
         e_code = 2'b00;
         since  = 0;
      end else begin
         e_read = acc;
         if (acc) begin
            since        = 0;
            last_acc_cyc = cyc;
            e_we   = cur.we;
            e_addr = cur.addr;
            e_data = cur.data;
            e_done = cur.done;
            e_err  = cur.err;
            e_busy = cur.busy;
            if (cur.err) e_code = 2'b01;
         end else if (e_busy) begin
            since++;
`ifdef BOOT_TIMEOUT_EN
            if (since == TMO) begin
               e_err  = 1'b1;
               e_code = 2'b10;
               e_busy = 1'b0;
            end
`endif
         end
      end
   endtask

   // Present one byte after a gap; ready stays up through the read cycle.
   task automatic send(input logic [7:0] b, input eff_t e, input int gap);
      repeat (gap) step();
      rx_data_i  = b;
      rx_ready_i = 1'b1;
      cur        = e;
      step();
      step();
      rx_ready_i = 1'b0;
   endtask

   function automatic logic [7:0] good_chk();
      logic [7:0] s = 8'h00;
      foreach (pl[i]) s = s + pl[i];
      return 8'h00 - s;
   endfunction

   task automatic send_frame(input logic [15:0] len, input logic [7:0] chk_byte,
                             input int maxgap);
      eff_t       e;
      logic [7:0] sum = 8'h00;
      logic [31:0] w = '0;
      e = '0;
      e.busy = 1'b1;
      send(8'hA5, e, $urandom_range(0, maxgap));
      send(len[7:0], e, $urandom_range(0, maxgap));
      send(len[15:8], e, $urandom_range(0, maxgap));
      for (int j = 0; j < 4 * int'(len); j++) begin
         e      = '0;
         e.busy = 1'b1;
         sum    = sum + pl[j];
         w      = {pl[j], w[31:8]};
         if (j % 4 == 3) begin
            e.we   = 1'b1;
            e.addr = BASE + AW'(j / 4);
            e.data = w;
         end
         send(pl[j], e, $urandom_range(0, maxgap));
      end
      e      = '0;
      e.done = (8'(sum + chk_byte) == 8'h00);
      e.err  = !e.done;
      send(chk_byte, e, $urandom_range(0, maxgap));
   endtask

   task automatic fill_payload(input int nbytes);
      pl.delete();
      for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      int   b_we, b_rd, b_done, b_err;
      eff_t e;
      logic [15:0] len;
      logic [7:0]  cb;

      reset      = 1'b1;
      rx_ready_i = 1'b0;
      rx_data_i  = 8'h00;
      cur        = '0;
      e_read = 0; e_we = 0; e_done = 0; e_err = 0; e_busy = 0; e_code = 0;
      e_addr = '0; e_data = '0;
      step();
      step();
      cmp_en = 1'b1;
      chk("reset_addr", 32'(mem_addr_o), 32'(BASE));
      chk("reset_wdata", mem_wdata_o, 32'h0);
      chk("reset_busy", 32'(busy_o), 32'h0);
      reset = 1'b0;
      step();

      // Directed: single word frame, good checksum
      pl = {8'h78, 8'h56, 8'h34, 8'h12};
      chk("model_chk_byte", 32'(good_chk()), 32'hEC);
      b_we = n_we; b_done = n_done; b_err = n_err;
      send_frame(16'd1, good_chk(), 0);
      repeat (2) step();
      chk("t1_writes", n_we - b_we, 1);
      chk("t1_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'(BASE));
      chk("t1_wdata", last_data, 32'h12345678);
      chk("t1_done", n_done - b_done, 1);
      chk("t1_err", n_err - b_err, 0);

      // Directed: bad checksum still writes the word
      b_we = n_we; b_done = n_done; b_err = n_err;
      send_frame(16'd1, 8'hD9, 1);
      repeat (2) step();
      chk("t2_writes", n_we - b_we, 1);
      chk("t2_err", n_err - b_err, 1);
      chk("t2_code", 32'(err_code_o), 32'h1);
      chk("t2_done", n_done - b_done, 0);

      // Directed: garbage then empty frame
      b_we = n_we; b_done = n_done; b_rd = n_read;
      e = '0;
      send(8'h00, e, 0);
      send(8'hFF, e, 0);
      pl.delete();
      send_frame(16'd0, 8'h00, 0);
      repeat (2) step();
      chk("t3_reads", n_read - b_rd, 6);
      chk("t3_writes", n_we - b_we, 0);
      chk("t3_done", n_done - b_done, 1);
      chk("t3_back_to_back_reads", n_consec, 0);

      // Directed: address wrap
      wr_addr.delete();
      b_done = n_done;
      fill_payload(8);
      send_frame(16'd2, good_chk(), 2);
      repeat (2) step();
      chk("t4_nwr", wr_addr.size(), 2);
      chk("t4_addr0", 32'(wr_addr[0]), 32'h3);
      chk("t4_addr1", 32'(wr_addr[1]), 32'h0);
      chk("t4_done", n_done - b_done, 1);

      // Directed: reset after two payload bytes
      b_we = n_we; b_done = n_done; b_err = n_err;
      e = '0;
      e.busy = 1'b1;
      send(8'hA5, e, 0);
      send(8'h03, e, 0);
      send(8'h00, e, 1);
      send(8'h11, e, 0);
      send(8'h22, e, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_busy", 32'(busy_o), 32'h0);
      chk("t5_code", 32'(err_code_o), 32'h0);
      repeat (3) step();
      chk("t5_writes", n_we - b_we, 0);
      chk("t5_pulses", (n_done - b_done) + (n_err - b_err), 0);
      fill_payload(4);
      send_frame(16'd1, good_chk(), 1);
      repeat (2) step();
      chk("t5_fresh_done", n_done - b_done, 1);

      // Randomized frames with garbage, gaps and occasional bad checksums
      for (int f = 0; f < 25; f++) begin
         int ng = $urandom_range(0, 2);
         for (int g = 0; g < ng; g++) begin
            cb = 8'($urandom_range(0, 255));
            if (cb == 8'hA5) cb = 8'h5A;
            e = '0;
            send(cb, e, $urandom_range(0, 3));
         end
         len = 16'($urandom_range(0, 5));
         fill_payload(4 * int'(len));
         cb = good_chk();
         if ($urandom_range(0, 3) == 0) cb = cb + 8'($urandom_range(1, 255));
         send_frame(len, cb, 3);
         repeat ($urandom_range(0, 3)) step();
      end

      // Inter-byte silence after a partial header
      b_err = n_err;
      e = '0;
      e.busy = 1'b1;
      send(8'hA5, e, 0);
      send(8'h01, e, 0);
`ifdef BOOT_TIMEOUT_EN
      repeat (TMO + 20) step();
      chk("t6_err", n_err - b_err, 1);
      chk("t6_err_delay", err_cyc - last_acc_cyc, TMO);
      chk("t6_code", 32'(err_code_o), 32'h2);
`else
      repeat (10000) step();
      chk("t6_no_err", n_err - b_err, 0);
      chk("t6_still_busy", 32'(busy_o), 32'h1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
